// File: rtl/maquina_maluca_pkg.sv
// Shared state codes for the espresso machine control FSM.
// The numeric values are exported on the status port and must not change.
package maquina_maluca_pkg;

    localparam logic [3:0] COD_IDLE                = 4'd1;
    localparam logic [3:0] COD_LIGAR_MAQUINA       = 4'd2;
    localparam logic [3:0] COD_VERIFICAR_AGUA      = 4'd3;
    localparam logic [3:0] COD_ENCHER_RESERVATORIO = 4'd4;
    localparam logic [3:0] COD_MOER_CAFE           = 4'd5;
    localparam logic [3:0] COD_COLOCAR_NO_FILTRO   = 4'd6;
    localparam logic [3:0] COD_PASSAR_AGITADOR     = 4'd7;
    localparam logic [3:0] COD_TAMPEAR             = 4'd8;
    localparam logic [3:0] COD_REALIZAR_EXTRACAO   = 4'd9;

    typedef enum logic [3:0] {
        IDLE                = COD_IDLE,
        LIGAR_MAQUINA       = COD_LIGAR_MAQUINA,
        VERIFICAR_AGUA      = COD_VERIFICAR_AGUA,
        ENCHER_RESERVATORIO = COD_ENCHER_RESERVATORIO,
        MOER_CAFE           = COD_MOER_CAFE,
        COLOCAR_NO_FILTRO   = COD_COLOCAR_NO_FILTRO,
        PASSAR_AGITADOR     = COD_PASSAR_AGITADOR,
        TAMPEAR             = COD_TAMPEAR,
        REALIZAR_EXTRACAO   = COD_REALIZAR_EXTRACAO
    } state_e;

endpackage

// File: rtl/maquina_maluca.sv
// Espresso machine brew sequencer: a start pulse in IDLE runs the fixed brew
// sequence once, refilling the reservoir when it is not known to be full.
module maquina_maluca
    import maquina_maluca_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] state
);

    state_e state_q, state_d;
    logic   agua_ok_q, agua_ok_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            agua_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            agua_ok_q <= agua_ok_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        agua_ok_d = agua_ok_q;
        case (state_q)
            IDLE:                state_d = start ? LIGAR_MAQUINA : IDLE;
            LIGAR_MAQUINA:       state_d = VERIFICAR_AGUA;
            VERIFICAR_AGUA:      state_d = agua_ok_q ? MOER_CAFE : ENCHER_RESERVATORIO;
            ENCHER_RESERVATORIO: begin
                state_d   = VERIFICAR_AGUA;
                agua_ok_d = 1'b1;
            end
            MOER_CAFE:           state_d = COLOCAR_NO_FILTRO;
            COLOCAR_NO_FILTRO:   state_d = PASSAR_AGITADOR;
            PASSAR_AGITADOR:     state_d = TAMPEAR;
            TAMPEAR:             state_d = REALIZAR_EXTRACAO;
            REALIZAR_EXTRACAO: begin
                // Each brew consumes the reservoir, so the next one refills first.
                state_d   = IDLE;
                agua_ok_d = 1'b0;
            end
            default:             state_d = IDLE;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_maquina_maluca.sv
// Randomized bench for maquina_maluca against a queue-based model of the brew recipe.
module tb_maquina_maluca;
    import maquina_maluca_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] state;

    int n_cmp;
    int n_err;

    int exp_state;
    bit agua;
    int pending[$];

    maquina_maluca dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (%b) expected %0d", tag, got, got, exp);
        end
    endtask

    task automatic model_reset();
        pending.delete();
        exp_state = 1;
        agua      = 1'b0;
    endtask

    // The model plans a whole brew as a list of upcoming codes when it is requested.
    task automatic model_edge(input bit s);
        int prev;
        prev = exp_state;
        if (pending.size() == 0 && s) begin
            pending.push_back(2);
            pending.push_back(3);
            if (!agua) begin
                pending.push_back(4);
                pending.push_back(3);
            end
            for (int k = 5; k <= 9; k++) pending.push_back(k);
            pending.push_back(1);
        end
        if (pending.size() > 0) exp_state = pending.pop_front();
        else                    exp_state = 1;
        if (prev == 4) agua = 1'b1;
        if (prev == 9) agua = 1'b0;
    endtask

    task automatic step(input string tag, input logic s);
        start = s;
        @(posedge clk);
        model_edge(s);
        #1;
        chk(tag, state, exp_state[3:0]);
    endtask

    task automatic async_reset(input string tag);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk(tag, state, exp_state[3:0]);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        bit found;
        n_cmp = 0;
        n_err = 0;
        model_reset();

        rst_n = 1'b0;
        start = 1'b0;
        #20;
        chk("reset", state, COD_IDLE);
        rst_n = 1'b1;
        step("post_reset_idle", 1'b0);
        step("post_reset_idle", 1'b0);

        step("brew1", 1'b1);
        for (int i = 0; i < 9; i++) step("brew1", 1'b0);

        step("brew2", 1'b1);
        for (int i = 0; i < 9; i++) step("brew2", 1'b0);

        for (int i = 0; i < 25; i++) step("start_held", 1'b1);
        for (int i = 0; i < 12; i++) step("drain", 1'b0);

        found = 1'b0;
        step("to_filtro", 1'b1);
        for (int i = 0; i < 20 && !found; i++) begin
            if (exp_state == 6) found = 1'b1;
            else step("to_filtro", 1'b0);
        end
        chk("reached_filtro", state, found ? COD_COLOCAR_NO_FILTRO : 4'd0);
        async_reset("async_reset_mid");
        step("refill_again", 1'b1);
        step("refill_again", 1'b0);
        step("refill_again", 1'b0);
        for (int i = 0; i < 10; i++) step("refill_drain", 1'b0);

        async_reset("idle_reset");
        for (int i = 0; i < 20; i++) step("idle_stable", 1'b0);

        for (int i = 0; i < 400; i++) begin
            step("random", ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 59) == 0) async_reset("random_reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
